cache_ctrl_fsm_lv1_il: RTL and testbench

Parametrised L1 instruction-cache controller and the next generation of the combinational LRU/address-split controller. It owns the valid bits, tags, data words and tree-PLRU state. It resolves CPU fetches as hits or misses and refills misses from L2 over a req/ack handshake. It supports per-line invalidate and whole-cache flush, and keeps hit/miss statistics.

---
 rtl/lv1_il_pkg.sv | 29 ++
 rtl/plru_tree_lv1.sv | 37 +++
 rtl/cache_ctrl_fsm_lv1_il.sv | 190 +++++++++++++++++++
 tb/tb_cache_ctrl_fsm_lv1_il.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lv1_il_pkg.sv
// Shared types and width helpers for the L1 instruction-cache controller.
// Pure declarations: no latency, no flow control.
package lv1_il_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MISS_REQ = 2'd2,
    FILL     = 2'd3
  } il_state_t;

  // Request-latch fields are sized for the widest geometry the controller is built with.
  localparam int REQ_TAG_WID   = 22;
  localparam int REQ_INDEX_WID = 8;

  typedef struct packed {
    logic [REQ_TAG_WID-1:0]   tag;
    logic [REQ_INDEX_WID-1:0] index;
  } il_req_t;

  function automatic int tag_wid(input int addr_wid, input int index_wid, input int offset_wid);
    return addr_wid - index_wid - offset_wid;
  endfunction

  function automatic int plru_wid(input int assoc_wid);
    return (1 << assoc_wid) - 1;
  endfunction

endpackage

// File: rtl/plru_tree_lv1.sv
// Combinational tree-PLRU: node bit 1 points the victim search right, 0 left.
// Zero latency; no flow control. Node k of level l sits at index 2**l-1+k.
module plru_tree_lv1
  import lv1_il_pkg::*;
#(
  parameter int ASSOC_WID = 2
) (
  input  logic [plru_wid(ASSOC_WID)-1:0] plru_bits,
  input  logic [ASSOC_WID-1:0]           accessed_way,
  output logic [plru_wid(ASSOC_WID)-1:0] update_bits,
  output logic [ASSOC_WID-1:0]           victim_way
);

  // Every node on the accessed way's path is turned to point away from it.
  always_comb begin
    update_bits = plru_bits;
    for (int l = 0; l < ASSOC_WID; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if ((accessed_way >> (ASSOC_WID - l)) == ASSOC_WID'(k)) begin
          update_bits[(1 << l) - 1 + k] = ~accessed_way[ASSOC_WID-1-l];
        end
      end
    end
  end

  always_comb begin
    victim_way = '0;
    for (int l = 0; l < ASSOC_WID; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if ((victim_way >> (ASSOC_WID - l)) == ASSOC_WID'(k)) begin
          victim_way[ASSOC_WID-1-l] = plru_bits[(1 << l) - 1 + k];
        end
      end
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm_lv1_il.sv
// L1 I-cache controller: hit completes 1 cycle after sampling, miss 1 cycle after lv2_ack;
// cpu_rd is sampled only in IDLE and the L2 request is held until acknowledged.
module cache_ctrl_fsm_lv1_il
  import lv1_il_pkg::*;
#(
  parameter int ADDR_WID   = 32,
  parameter int DATA_WID   = 32,
  parameter int ASSOC_WID  = 2,
  parameter int INDEX_WID  = 8,
  parameter int OFFSET_WID = 2,
  parameter int CNT_WID    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_rd,
  input  logic [ADDR_WID-1:0] addr_bus_cpu_lv1,
  output logic [DATA_WID-1:0] data_bus_cpu_lv1,
  output logic                cpu_rd_done,
  output logic                cpu_busy,
  output logic                lv2_rd_req,
  output logic [ADDR_WID-1:0] lv2_addr,
  input  logic [DATA_WID-1:0] lv2_data,
  input  logic                lv2_ack,
  input  logic                inv_req,
  input  logic [ADDR_WID-1:0] inv_addr,
  input  logic                flush,
  output logic [CNT_WID-1:0]  hit_cnt,
  output logic [CNT_WID-1:0]  miss_cnt
);

  localparam int TAG_WID  = tag_wid(ADDR_WID, INDEX_WID, OFFSET_WID);
  localparam int WAYS     = 1 << ASSOC_WID;
  localparam int SETS     = 1 << INDEX_WID;
  localparam int PLRU_WID = plru_wid(ASSOC_WID);

  il_state_t            state_q, state_d;
  il_req_t              req_q, req_d;
  logic [DATA_WID-1:0]  fill_dat_q, fill_dat_d;
  logic [CNT_WID-1:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      valid_d [SETS];
  logic [PLRU_WID-1:0]  plru_q [SETS];
  logic [PLRU_WID-1:0]  plru_d [SETS];
  logic [TAG_WID-1:0]   tag_mem_q [SETS][WAYS];
  logic [DATA_WID-1:0]  dat_mem_q [SETS][WAYS];

  logic [INDEX_WID-1:0] idx, inv_idx;
  logic [TAG_WID-1:0]   tag, inv_tag;
  logic [WAYS-1:0]      hit_vec, inv_vec;
  logic [ASSOC_WID-1:0] hit_way, free_way, fill_way, victim_way, access_way;
  logic [PLRU_WID-1:0]  plru_upd;
  logic                 hit, any_free, fill_we, unused_offsets;

  assign idx     = req_q.index[INDEX_WID-1:0];
  assign tag     = req_q.tag[TAG_WID-1:0];
  assign inv_idx = inv_addr[OFFSET_WID +: INDEX_WID];
  assign inv_tag = inv_addr[ADDR_WID-1 -: TAG_WID];
  assign unused_offsets = ^{inv_addr[OFFSET_WID-1:0], addr_bus_cpu_lv1[OFFSET_WID-1:0]};

  always_comb begin
    hit_way  = '0;
    free_way = '0;
    any_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_mem_q[idx][w] == tag);
      inv_vec[w] = valid_q[inv_idx][w] && (tag_mem_q[inv_idx][w] == inv_tag);
      if (hit_vec[w]) hit_way = ASSOC_WID'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        free_way = ASSOC_WID'(w);
        any_free = 1'b1;
      end
    end
  end

  assign hit        = |hit_vec;
  assign fill_way   = any_free ? free_way : victim_way;
  assign access_way = (state_q == FILL) ? fill_way : hit_way;

  plru_tree_lv1 #(.ASSOC_WID(ASSOC_WID)) u_plru (
    .plru_bits    (plru_q[idx]),
    .accessed_way (access_way),
    .update_bits  (plru_upd),
    .victim_way   (victim_way)
  );

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    fill_dat_d       = fill_dat_q;
    hit_cnt_d        = hit_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    valid_d          = valid_q;
    plru_d           = plru_q;
    fill_we          = 1'b0;
    data_bus_cpu_lv1 = '0;
    cpu_rd_done      = 1'b0;
    lv2_rd_req       = 1'b0;
    lv2_addr         = '0;
    case (state_q)
      IDLE: begin
        if (cpu_rd) begin
          req_d.tag   = REQ_TAG_WID'(addr_bus_cpu_lv1[ADDR_WID-1 -: TAG_WID]);
          req_d.index = REQ_INDEX_WID'(addr_bus_cpu_lv1[OFFSET_WID +: INDEX_WID]);
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          cpu_rd_done      = 1'b1;
          data_bus_cpu_lv1 = dat_mem_q[idx][hit_way];
          plru_d[idx]      = plru_upd;
          hit_cnt_d        = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
          state_d          = IDLE;
        end else begin
          miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
          state_d    = MISS_REQ;
        end
      end
      MISS_REQ: begin
        lv2_rd_req = 1'b1;
        lv2_addr   = {tag, idx, {OFFSET_WID{1'b0}}};
        if (lv2_ack) begin
          fill_dat_d = lv2_data;
          state_d    = FILL;
        end
      end
      FILL: begin
        cpu_rd_done            = 1'b1;
        data_bus_cpu_lv1       = fill_dat_q;
        fill_we                = 1'b1;
        valid_d[idx][fill_way] = 1'b1;
        plru_d[idx]            = plru_upd;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Invalidation is applied after the fill so it wins on the line being filled.
    if (inv_req) begin
      for (int w = 0; w < WAYS; w++) begin
        if (inv_vec[w]) valid_d[inv_idx][w] = 1'b0;
      end
      if ((state_q == FILL) && (inv_idx == idx) && (inv_tag == tag)) valid_d[idx][fill_way] = 1'b0;
    end
    if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_d[s] = '0;
        plru_d[s]  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      fill_dat_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fill_dat_q <= fill_dat_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      plru_q     <= plru_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem_q[idx][fill_way] <= tag;
      dat_mem_q[idx][fill_way] <= fill_dat_q;
    end
  end

  assign cpu_busy = (state_q != IDLE);
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // A tag resident in two ways of one set means the fill logic is broken.
  assert property (@(posedge clk) disable iff (rst) (state_q == LOOKUP) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_cache_ctrl_fsm_lv1_il.sv
// Directed and random fetch traffic against a set/way/tree-PLRU reference model.
module tb_cache_ctrl_fsm_lv1_il;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd;
  logic [31:0] addr_bus_cpu_lv1;
  logic [31:0] data_bus_cpu_lv1;
  logic        cpu_rd_done;
  logic        cpu_busy;
  logic        lv2_rd_req;
  logic [31:0] lv2_addr;
  logic [31:0] lv2_data;
  logic        lv2_ack;
  logic        inv_req;
  logic [31:0] inv_addr;
  logic        flush;
  logic [3:0]  hit_cnt;
  logic [3:0]  miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl_fsm_lv1_il #(.CNT_WID(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_rd           (cpu_rd),
    .addr_bus_cpu_lv1 (addr_bus_cpu_lv1),
    .data_bus_cpu_lv1 (data_bus_cpu_lv1),
    .cpu_rd_done      (cpu_rd_done),
    .cpu_busy         (cpu_busy),
    .lv2_rd_req       (lv2_rd_req),
    .lv2_addr         (lv2_addr),
    .lv2_data         (lv2_data),
    .lv2_ack          (lv2_ack),
    .inv_req          (inv_req),
    .inv_addr         (inv_addr),
    .flush            (flush),
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: 256 sets x 4 ways, 3 tree bits per set, saturating 4-bit counters.
  bit          m_vld  [256][4];
  logic [21:0] m_tag  [256][4];
  bit          m_plru [256][3];
  int          m_hits, m_miss;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic int set_of(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic logic [21:0] tag_of(input logic [31:0] a);
    return a[31:10];
  endfunction

  function automatic logic [31:0] dfun(input logic [31:0] la);
    return (la == 32'h0000_1004) ? 32'hDEAD_BEEF : ((la * 32'h9E37_79B1) ^ 32'h1234_5678);
  endfunction

  function automatic logic [31:0] ev(input int i);
    return {22'(32'h40 + i), 8'h01, 2'b00};
  endfunction

  function automatic int sat(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  function automatic int m_find(input logic [31:0] a);
    for (int w = 0; w < 4; w++)
      if (m_vld[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return w;
    return -1;
  endfunction

  // Walk from the root; each node on the path is pointed at the other child.
  function automatic void m_touch(input int s, input int w);
    int n = 0;
    for (int l = 1; l >= 0; l--) begin
      int d = (w >> l) & 1;
      m_plru[s][n] = (d == 0);
      n = 2 * n + 1 + d;
    end
  endfunction

  function automatic int m_victim(input int s);
    int n = 0;
    int w = 0;
    for (int i = 0; i < 4; i++) if (!m_vld[s][i]) return i;
    for (int l = 0; l < 2; l++) begin
      int d = m_plru[s][n] ? 1 : 0;
      w = 2 * w + d;
      n = 2 * n + 1 + d;
    end
    return w;
  endfunction

  function automatic void m_inv(input logic [31:0] a);
    int w = m_find(a);
    if (w >= 0) m_vld[set_of(a)][w] = 1'b0;
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < 256; s++) begin
      for (int w = 0; w < 4; w++) m_vld[s][w] = 1'b0;
      for (int n = 0; n < 3; n++) m_plru[s][n] = 1'b0;
    end
  endfunction

  function automatic void m_reset();
    m_flush();
    m_hits = 0;
    m_miss = 0;
  endfunction

  // mode: 0 plain, 1 inv_req in the FILL cycle, 2 flush in MISS_REQ, 3 rst in MISS_REQ.
  task automatic do_fetch(input logic [31:0] a, input int dly, input int mode, input bit hold,
                          output bit got_hit);
    int          s, w;
    bit          exp_hit;
    logic [31:0] la;
    la      = {a[31:2], 2'b00};
    s       = set_of(a);
    w       = m_find(a);
    exp_hit = (w >= 0);
    cpu_rd  = 1'b1;
    addr_bus_cpu_lv1 = a;
    @(negedge clk);
    got_hit = cpu_rd_done;
    check("lookup_busy", cpu_busy, 1);
    check("lookup_hit", cpu_rd_done, exp_hit);
    check("lookup_no_req", lv2_rd_req, 0);
    if (!hold || exp_hit) cpu_rd = 1'b0;
    addr_bus_cpu_lv1 = $urandom;
    if (exp_hit) begin
      check("hit_data", data_bus_cpu_lv1, dfun(la));
      m_touch(s, w);
      m_hits = sat(m_hits);
    end else begin
      m_miss = sat(m_miss);
      @(negedge clk);
      check("req", lv2_rd_req, 1);
      check("req_addr", lv2_addr, la);
      check("req_no_done", cpu_rd_done, 0);
      if (mode == 3) begin
        rst    = 1'b1;
        cpu_rd = 1'b0;
        #1;
        check("rst_req_drop", lv2_rd_req, 0);
        check("rst_busy", cpu_busy, 0);
        m_reset();
        @(negedge clk);
        rst      = 1'b0;
        lv2_ack  = 1'b1;
        lv2_data = dfun(la);
        @(negedge clk);
        lv2_ack = 1'b0;
        check("rst_ack_ignored", cpu_rd_done, 0);
        check("rst_ack_idle", cpu_busy, 0);
        @(negedge clk);
        check("rst_no_done", cpu_rd_done, 0);
      end else begin
        if (mode == 2) begin
          flush = 1'b1;
          @(negedge clk);
          flush = 1'b0;
          m_flush();
          check("flush_req_held", lv2_rd_req, 1);
        end
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          check("req_held", lv2_rd_req, 1);
          check("req_addr_stable", lv2_addr, la);
        end
        lv2_ack  = 1'b1;
        lv2_data = dfun(la);
        @(negedge clk);
        lv2_ack  = 1'b0;
        lv2_data = $urandom;
        cpu_rd   = 1'b0;
        check("fill_done", cpu_rd_done, 1);
        check("fill_data", data_bus_cpu_lv1, dfun(la));
        check("fill_req_drop", lv2_rd_req, 0);
        w = m_victim(s);
        m_vld[s][w] = 1'b1;
        m_tag[s][w] = tag_of(a);
        m_touch(s, w);
        if (mode == 1) begin
          inv_req  = 1'b1;
          inv_addr = a;
          m_inv(a);
        end
      end
    end
    @(negedge clk);
    inv_req = 1'b0;
    check("idle_busy", cpu_busy, 0);
    check("idle_no_done", cpu_rd_done, 0);
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic inv_pulse(input logic [31:0] a);
    inv_req  = 1'b1;
    inv_addr = a;
    @(negedge clk);
    inv_req = 1'b0;
    m_inv(a);
    check("inv_idle", cpu_busy, 0);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_flush();
    check("flush_hit_cnt", hit_cnt, m_hits);
    check("flush_miss_cnt", miss_cnt, m_miss);
  endtask

  initial begin
    bit          h;
    int          mm, hc;
    logic [31:0] a;
    int          r;
    cpu_rd = 1'b0; addr_bus_cpu_lv1 = '0; lv2_data = '0; lv2_ack = 1'b0;
    inv_req = 1'b0; inv_addr = '0; flush = 1'b0; rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_busy", cpu_busy, 0);
    check("rst_done", cpu_rd_done, 0);
    check("rst_data", data_bus_cpu_lv1, 0);
    check("rst_lv2_req", lv2_rd_req, 0);
    check("rst_lv2_addr", lv2_addr, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    do_fetch(32'h0000_1004, 2, 0, 1'b1, h);
    check("cold_is_miss", h, 0);
    check("cold_miss_cnt", miss_cnt, 1);
    do_fetch(32'h0000_1004, 0, 0, 1'b0, h);
    check("warm_is_hit", h, 1);
    check("warm_hit_cnt", hit_cnt, 1);

    inv_pulse(32'h0000_1004);
    do_fetch(32'h0000_1004, 1, 1, 1'b0, h);
    check("inv_then_miss", h, 0);
    do_fetch(32'h0000_1004, 1, 0, 1'b0, h);
    check("inv_in_fill_left_invalid", h, 0);

    flush_pulse();
    for (int i = 0; i < 3; i++) do_fetch(ev(i), 1, 0, 1'b0, h);
    do_fetch(ev(0), 0, 0, 1'b0, h);
    check("ev_touch_way0", h, 1);
    do_fetch(ev(3), 0, 0, 1'b1, h);
    do_fetch(ev(4), 2, 0, 1'b0, h);
    do_fetch(ev(0), 0, 0, 1'b0, h);
    check("ev_way0_kept", h, 1);
    do_fetch(ev(1), 1, 0, 1'b0, h);
    check("ev_victim_miss", h, 0);

    mm = miss_cnt;
    hc = hit_cnt;
    do_fetch(32'h0000_2008, 1, 2, 1'b1, h);
    check("flush_mid_miss_cnt", miss_cnt, mm + 1);
    check("flush_mid_hit_cnt", hit_cnt, hc);
    do_fetch(32'h0000_2008, 0, 0, 1'b0, h);
    check("flush_mid_fill_kept", h, 1);
    do_fetch(ev(0), 1, 0, 1'b0, h);
    check("flush_resident_gone", h, 0);

    do_fetch(32'h0000_3000, 1, 3, 1'b0, h);
    check("rst_mid_hit_cnt", hit_cnt, 0);
    check("rst_mid_miss_cnt", miss_cnt, 0);
    do_fetch(ev(0), 0, 0, 1'b0, h);
    check("rst_clears_valid", h, 0);
    for (int i = 0; i < 20; i++) do_fetch(ev(0), 0, 0, 1'($urandom_range(0, 1)), h);
    check("hit_cnt_saturates", hit_cnt, 15);

    for (int it = 0; it < 300; it++) begin
      a = {22'(32'h10 + $urandom_range(0, 5)), 8'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      r = $urandom_range(0, 19);
      if (r == 0) flush_pulse();
      else if (r < 3) inv_pulse(a);
      else do_fetch(a, $urandom_range(0, 3), (r == 3) ? 1 : 0, 1'($urandom_range(0, 1)), h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
